sync_fifo_v2: RTL and testbench

SYNC_FIFO_V2 -- requirements
Module: sync_fifo_v2

---
 rtl/sync_fifo_v2_if.sv | 28 ++
 rtl/sync_fifo_v2.sv | 104 ++++++++++
 tb/tb_sync_fifo_v2.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/sync_fifo_v2_if.sv
// Handshake and status bundle between a FIFO producer/consumer (master)
// and the sync_fifo_v2 storage block (slave).
interface sync_fifo_v2_if #(
  parameter int WIDTH     = 8,
  parameter int PTR_WIDTH = 4
);
  logic                 wr_en;
  logic [WIDTH-1:0]     wr_data;
  logic                 rd_en;
  logic [WIDTH-1:0]     rd_data;
  logic                 full;
  logic                 empty;
  logic                 almost_full;
  logic                 almost_empty;
  logic [PTR_WIDTH:0]   count;
  logic                 wr_error;
  logic                 rd_error;

  modport master (
    output wr_en, wr_data, rd_en,
    input  rd_data, full, empty, almost_full, almost_empty, count, wr_error, rd_error
  );

  modport slave (
    input  wr_en, wr_data, rd_en,
    output rd_data, full, empty, almost_full, almost_empty, count, wr_error, rd_error
  );
endinterface

// File: rtl/sync_fifo_v2.sv
// Single-clock FIFO with registered status flags, overflow/underflow pulses and
// selectable registered-read or first-word-fall-through output.
module sync_fifo_v2 #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 16,
  parameter int PTR_WIDTH = 4,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = 2,
  parameter int FWFT      = 0
) (
  input  logic          clk,
  input  logic          rst,
  sync_fifo_v2_if.slave bus
);

  localparam logic [PTR_WIDTH:0] ONE     = (PTR_WIDTH+1)'(1);
  localparam logic [PTR_WIDTH:0] DEPTH_C = (PTR_WIDTH+1)'(DEPTH);
  localparam logic [PTR_WIDTH:0] AF_C    = (PTR_WIDTH+1)'(AF_THRESH);
  localparam logic [PTR_WIDTH:0] AE_C    = (PTR_WIDTH+1)'(AE_THRESH);

  logic [WIDTH-1:0]   mem [DEPTH];

  logic [PTR_WIDTH:0] wr_ptr;
  logic [PTR_WIDTH:0] rd_ptr;
  logic [PTR_WIDTH:0] count_q;
  logic               full_q;
  logic               empty_q;
  logic               af_q;
  logic               ae_q;
  logic               wr_error_q;
  logic               rd_error_q;
  logic [WIDTH-1:0]   rd_data_q;

  logic               wr_acc;
  logic               rd_acc;
  logic [PTR_WIDTH:0] wr_ptr_nxt;
  logic [PTR_WIDTH:0] rd_ptr_nxt;
  logic [PTR_WIDTH:0] count_nxt;
  logic               head_bypass;
  logic               rd_load;
  logic [WIDTH-1:0]   head_nxt;

  always_comb begin
    wr_acc      = rst && bus.wr_en && !full_q;
    rd_acc      = rst && bus.rd_en && !empty_q;
    wr_ptr_nxt  = wr_acc ? wr_ptr + ONE : wr_ptr;
    rd_ptr_nxt  = rd_acc ? rd_ptr + ONE : rd_ptr;
    count_nxt   = wr_ptr_nxt - rd_ptr_nxt;
    // In FWFT mode the word being written becomes the head when nothing
    // else remains after this edge's pop; memory still holds the old value.
    head_bypass = wr_acc && (count_q == (rd_acc ? ONE : '0));
    if (FWFT != 0) begin
      rd_load  = (count_nxt != '0);
      head_nxt = head_bypass ? bus.wr_data : mem[rd_ptr_nxt[PTR_WIDTH-1:0]];
    end else begin
      rd_load  = rd_acc;
      head_nxt = mem[rd_ptr[PTR_WIDTH-1:0]];
    end
  end

  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wr_ptr[PTR_WIDTH-1:0]] <= bus.wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      af_q       <= 1'b0;
      ae_q       <= 1'b1;
      wr_error_q <= 1'b0;
      rd_error_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      wr_ptr     <= wr_ptr_nxt;
      rd_ptr     <= rd_ptr_nxt;
      count_q    <= count_nxt;
      full_q     <= (count_nxt == DEPTH_C);
      empty_q    <= (count_nxt == '0);
      af_q       <= (count_nxt >= AF_C);
      ae_q       <= (count_nxt <= AE_C);
      wr_error_q <= bus.wr_en && full_q;
      rd_error_q <= bus.rd_en && empty_q;
      if (rd_load) begin
        rd_data_q <= head_nxt;
      end
    end
  end

  assign bus.rd_data      = rd_data_q;
  assign bus.count        = count_q;
  assign bus.full         = full_q;
  assign bus.empty        = empty_q;
  assign bus.almost_full  = af_q;
  assign bus.almost_empty = ae_q;
  assign bus.wr_error     = wr_error_q;
  assign bus.rd_error     = rd_error_q;

endmodule

// File: tb/tb_sync_fifo_v2.sv
// Drives a registered-read and an FWFT instance with identical stimulus and
// compares both against a queue-based model of FIFO behaviour.
module tb_sync_fifo_v2;
  localparam int WIDTH = 8;
  localparam int DEPTH = 16;
  localparam int PW    = 4;
  localparam int AF    = 14;
  localparam int AE    = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sync_fifo_v2_if #(.WIDTH(WIDTH), .PTR_WIDTH(PW)) bus0 ();
  sync_fifo_v2_if #(.WIDTH(WIDTH), .PTR_WIDTH(PW)) bus1 ();

  sync_fifo_v2 #(.WIDTH(WIDTH), .DEPTH(DEPTH), .PTR_WIDTH(PW), .AF_THRESH(AF),
                 .AE_THRESH(AE), .FWFT(0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  sync_fifo_v2 #(.WIDTH(WIDTH), .DEPTH(DEPTH), .PTR_WIDTH(PW), .AF_THRESH(AF),
                 .AE_THRESH(AE), .FWFT(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  int n_checks = 0;
  int n_fail   = 0;

  logic [WIDTH-1:0] q[$];
  logic [WIDTH-1:0] m_rd0, m_rd1;
  bit               m_werr, m_rerr;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", tag, $time, obs, exp);
    end
  endtask

  task automatic compare_all();
    int sz;
    sz = q.size();
    check("count0",   32'(bus0.count),        32'(sz));
    check("full0",    32'(bus0.full),         32'(sz == DEPTH));
    check("empty0",   32'(bus0.empty),        32'(sz == 0));
    check("afull0",   32'(bus0.almost_full),  32'(sz >= AF));
    check("aempty0",  32'(bus0.almost_empty), 32'(sz <= AE));
    check("wr_err0",  32'(bus0.wr_error),     32'(m_werr));
    check("rd_err0",  32'(bus0.rd_error),     32'(m_rerr));
    check("rd_data0", 32'(bus0.rd_data),      32'(m_rd0));
    check("count1",   32'(bus1.count),        32'(sz));
    check("empty1",   32'(bus1.empty),        32'(sz == 0));
    check("wr_err1",  32'(bus1.wr_error),     32'(m_werr));
    check("rd_err1",  32'(bus1.rd_error),     32'(m_rerr));
    check("rd_data1", 32'(bus1.rd_data),      32'(m_rd1));
  endtask

  // One clock: apply inputs on the falling edge, advance the model on the
  // rising edge, then compare shortly after it.
  task automatic step(input bit n_rst, input bit we, input logic [WIDTH-1:0] wd, input bit re);
    bit was_full, was_empty;
    @(negedge clk);
    rst = n_rst;
    bus0.wr_en = we; bus0.wr_data = wd; bus0.rd_en = re;
    bus1.wr_en = we; bus1.wr_data = wd; bus1.rd_en = re;
    @(posedge clk);
    if (!n_rst) begin
      q.delete();
      m_rd0 = '0; m_rd1 = '0; m_werr = 1'b0; m_rerr = 1'b0;
    end else begin
      was_full  = (q.size() == DEPTH);
      was_empty = (q.size() == 0);
      m_werr = we && was_full;
      m_rerr = re && was_empty;
      if (re && !was_empty) m_rd0 = q.pop_front();
      if (we && !was_full)  q.push_back(wd);
      if (q.size() > 0)     m_rd1 = q[0];
    end
    #1;
    compare_all();
  endtask

  initial begin
    rst = 1'b0;
    bus0.wr_en = 1'b0; bus0.wr_data = '0; bus0.rd_en = 1'b0;
    bus1.wr_en = 1'b0; bus1.wr_data = '0; bus1.rd_en = 1'b0;
    m_rd0 = '0; m_rd1 = '0; m_werr = 1'b0; m_rerr = 1'b0;

    // Reset wins over simultaneous requests
    step(0, 1, 8'h55, 1);
    step(0, 1, 8'h66, 1);
    check("rst_count", 32'(bus0.count), 0);
    check("rst_empty", 32'(bus0.empty), 1);
    check("rst_aempty", 32'(bus0.almost_empty), 1);

    // Fill with i*2
    for (int i = 0; i < 16; i++) begin
      step(1, 1, 8'(i * 2), 0);
      if (i == 1) check("aempty_after2", 32'(bus0.almost_empty), 1);
      if (i == 2) check("aempty_after3", 32'(bus0.almost_empty), 0);
    end
    check("fill_full", 32'(bus0.full), 1);
    check("fill_count", 32'(bus0.count), 16);
    check("fill_afull", 32'(bus0.almost_full), 1);

    // Overflow attempts then drain in order
    for (int i = 0; i < 4; i++) begin
      step(1, 1, 8'hEE, 0);
      check("ovf_pulse", 32'(bus0.wr_error), 1);
      check("ovf_count", 32'(bus0.count), 16);
    end
    step(1, 0, 8'h00, 0);
    check("ovf_pulse_end", 32'(bus0.wr_error), 0);
    for (int i = 0; i < 16; i++) begin
      step(1, 0, 8'h00, 1);
      check("drain_data", 32'(bus0.rd_data), 32'(i * 2));
    end
    check("drain_empty", 32'(bus0.empty), 1);

    // Underflow from a fresh reset
    step(0, 0, 8'h00, 0);
    for (int i = 0; i < 16; i++) begin
      step(1, 0, 8'h00, 1);
      check("udf_pulse", 32'(bus0.rd_error), 1);
      check("udf_rd_data", 32'(bus0.rd_data), 0);
    end

    // Steady state at 8 entries, then full with simultaneous wr/rd
    step(0, 0, 8'h00, 0);
    for (int i = 0; i < 8; i++) step(1, 1, 8'(8'h40 + i), 0);
    for (int i = 0; i < 10; i++) begin
      step(1, 1, 8'(8'h80 + i), 1);
      check("pass_count", 32'(bus0.count), 8);
    end
    check("pass_last_data", 32'(bus0.rd_data), 32'h80 + 1);
    for (int i = 0; i < 8; i++) step(1, 1, 8'(8'hC0 + i), 0);
    step(1, 1, 8'hFF, 1);
    check("full_both_werr", 32'(bus0.wr_error), 1);
    check("full_both_count", 32'(bus0.count), 15);

    // Interleaved pairs wrap the pointers three times
    step(0, 0, 8'h00, 0);
    for (int i = 0; i < 48; i++) begin
      step(1, 1, 8'($urandom), 0);
      check("pair_count1", 32'(bus0.count), 1);
      step(1, 0, 8'h00, 1);
      check("pair_count0", 32'(bus0.count), 0);
    end

    // FWFT head visible without a read, then reset at depth 10
    step(0, 0, 8'h00, 0);
    step(1, 1, 8'hA5, 0);
    check("fwft_head", 32'(bus1.rd_data), 32'hA5);
    check("fwft_nonempty", 32'(bus1.empty), 0);
    for (int i = 0; i < 9; i++) step(1, 1, 8'(i), 0);
    check("fwft_count10", 32'(bus1.count), 10);
    step(0, 0, 8'h00, 0);
    check("fwft_rst_rd_data", 32'(bus1.rd_data), 0);
    check("fwft_rst_empty", 32'(bus1.empty), 1);
    check("fwft_rst_afull", 32'(bus1.almost_full), 0);

    // Randomized traffic with phases biased toward filling and draining
    for (int i = 0; i < 3000; i++) begin
      int phase, pw, pr;
      phase = (i / 150) % 3;
      pw = (phase == 0) ? 80 : (phase == 1) ? 25 : 50;
      pr = (phase == 0) ? 25 : (phase == 1) ? 80 : 50;
      step(($urandom_range(0, 399) != 0),
           ($urandom_range(0, 99) < pw),
           8'($urandom),
           ($urandom_range(0, 99) < pr));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
